// File: rtl/gamepad_pkg.sv
// Shared constants for the two-player DB9 gamepad scan scheduler: button and
// pin indices, scheduler state encoding and the per-phase sampling helper.
package gamepad_pkg;

    localparam int NUM_BUTTONS = 12;
    localparam int BTN_IDX_W   = $clog2(NUM_BUTTONS);
    localparam int NUM_PINS    = 6;
    localparam int NUM_PHASES  = 8;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    localparam int PIN_1 = 0;
    localparam int PIN_2 = 1;
    localparam int PIN_3 = 2;
    localparam int PIN_4 = 3;
    localparam int PIN_6 = 4;
    localparam int PIN_9 = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN_P0 = 2'd1,
        ST_SCAN_P1 = 2'd2
    } scan_state_e;

    // Merge the active-low pins seen in one select phase into the shadow word.
    function automatic logic [NUM_BUTTONS-1:0] sample_phase(
        input logic [2:0]             phase,
        input logic [NUM_PINS-1:0]    pins,
        input logic [NUM_BUTTONS-1:0] shadow
    );
        logic [NUM_BUTTONS-1:0] s;
        s = shadow;
        case (phase)
            3'd1: begin
                s[BTN_A]     = ~pins[PIN_6];
                s[BTN_START] = ~pins[PIN_9];
            end
            3'd2: begin
                s[BTN_UP]    = ~pins[PIN_1];
                s[BTN_DOWN]  = ~pins[PIN_2];
                s[BTN_LEFT]  = ~pins[PIN_3];
                s[BTN_RIGHT] = ~pins[PIN_4];
            end
            3'd4: begin
                s[BTN_B]     = ~pins[PIN_6];
                s[BTN_C]     = ~pins[PIN_9];
            end
            3'd6: begin
                s[BTN_Z]     = ~pins[PIN_1];
                s[BTN_Y]     = ~pins[PIN_2];
                s[BTN_X]     = ~pins[PIN_3];
                s[BTN_MODE]  = ~pins[PIN_4];
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/gamepad_evt_arbiter.sv
// Per-player pending press masks with a round-robin, registered valid/ready
// event port; one single-button event is presented at a time.
module gamepad_evt_arbiter
    import gamepad_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_p0_i,
    input  logic [NUM_BUTTONS-1:0] old_p0_i,
    input  logic [NUM_BUTTONS-1:0] new_p0_i,
    input  logic                   commit_p1_i,
    input  logic [NUM_BUTTONS-1:0] old_p1_i,
    input  logic [NUM_BUTTONS-1:0] new_p1_i,
    input  logic                   evt_ready_i,
    output logic                   evt_valid_o,
    output logic                   evt_player_o,
    output logic [BTN_IDX_W-1:0]   evt_button_o
);

    logic [NUM_BUTTONS-1:0] pend0_q, pend0_d;
    logic [NUM_BUTTONS-1:0] pend1_q, pend1_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;
    logic                   player_q, player_d;
    logic [BTN_IDX_W-1:0]   button_q, button_d;

    logic                   ack;
    logic                   hold;
    logic [NUM_BUTTONS-1:0] ack_mask;
    logic [NUM_BUTTONS-1:0] set0, set1;
    logic [NUM_BUTTONS-1:0] sel_mask;
    logic                   any0, any1, pick;
    logic [BTN_IDX_W-1:0]   sel_btn;

    always_comb begin
        ack      = valid_q && evt_ready_i;
        hold     = valid_q && !evt_ready_i;
        ack_mask = {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << button_q;

        set0 = commit_p0_i ? (new_p0_i & ~old_p0_i) : '0;
        set1 = commit_p1_i ? (new_p1_i & ~old_p1_i) : '0;

        // A press detected in the same cycle as the acknowledge of that bit wins.
        pend0_d = ((ack && !player_q) ? (pend0_q & ~ack_mask) : pend0_q) | set0;
        pend1_d = ((ack &&  player_q) ? (pend1_q & ~ack_mask) : pend1_q) | set1;
        last_d  = ack ? player_q : last_q;

        any0 = |pend0_d;
        any1 = |pend1_d;
        pick = ~last_d;
        if (pick && !any1) begin
            pick = 1'b0;
        end else if (!pick && !any0) begin
            pick = 1'b1;
        end

        sel_mask = pick ? pend1_d : pend0_d;
        sel_btn  = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (sel_mask[i]) begin
                sel_btn = BTN_IDX_W'(i);
            end
        end

        valid_d  = valid_q;
        player_d = player_q;
        button_d = button_q;
        if (!hold) begin
            valid_d  = any0 | any1;
            player_d = pick;
            button_d = sel_btn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend0_q  <= '0;
            pend1_q  <= '0;
            last_q   <= 1'b1;
            valid_q  <= 1'b0;
            player_q <= 1'b0;
            button_q <= '0;
        end else begin
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            player_q <= player_d;
            button_q <= button_d;
        end
    end

    assign evt_valid_o  = valid_q;
    assign evt_player_o = player_q;
    assign evt_button_o = button_q;

endmodule

// File: rtl/gamepad_scan_scheduler.sv
// Two-player DB9 scan scheduler: shared phase sequencer, period timer, sampling
// and atomic commit. Optional commit debounce via `GAMEPAD_DEBOUNCE_EN.
module gamepad_scan_scheduler
    import gamepad_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int SCAN_PERIOD  = 833333
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PINS-1:0]    pins_p0,
    input  logic [NUM_PINS-1:0]    pins_p1,
    output logic                   select_p0,
    output logic                   select_p1,
    input  logic                   scan_req,
    output logic                   busy,
    output logic [NUM_BUTTONS-1:0] buttons_p0,
    output logic [NUM_BUTTONS-1:0] buttons_p1,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic                   evt_player,
    output logic [BTN_IDX_W-1:0]   evt_button
);

    localparam int PH_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int PER_W = $clog2(SCAN_PERIOD);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
    localparam logic [2:0]       PHASE_LAST = 3'(NUM_PHASES - 1);

    scan_state_e            state_q, state_d;
    logic [2:0]             phase_q, phase_d;
    logic [PH_W-1:0]        pcnt_q, pcnt_d;
    logic [PER_W-1:0]       per_q, per_d;
    logic                   pend_q, pend_d;
    logic [NUM_BUTTONS-1:0] sh0_q, sh0_d;
    logic [NUM_BUTTONS-1:0] sh1_q, sh1_d;
    logic [NUM_BUTTONS-1:0] btn0_q, btn0_d;
    logic [NUM_BUTTONS-1:0] btn1_q, btn1_d;
    logic [NUM_BUTTONS-1:0] new0, new1;
    logic                   commit0, commit1;
    logic                   period_hit, start, phase_last;

`ifdef GAMEPAD_DEBOUNCE_EN
    logic [NUM_BUTTONS-1:0] raw0_q, raw1_q;
    logic [NUM_BUTTONS-1:0] stable0, stable1;

    // A bit may only move when this scan agrees with the previous raw scan.
    always_comb begin
        stable0 = ~(sh0_q ^ raw0_q);
        stable1 = ~(sh1_q ^ raw1_q);
        new0    = (sh0_q & stable0) | (btn0_q & ~stable0);
        new1    = (sh1_q & stable1) | (btn1_q & ~stable1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw0_q <= '0;
            raw1_q <= '0;
        end else begin
            if (commit0) begin
                raw0_q <= sh0_q;
            end
            if (commit1) begin
                raw1_q <= sh1_q;
            end
        end
    end
`else
    always_comb begin
        new0 = sh0_q;
        new1 = sh1_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pcnt_d  = pcnt_q;
        pend_d  = pend_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        commit0 = 1'b0;
        commit1 = 1'b0;

        period_hit = (per_q == PER_LAST);
        per_d      = period_hit ? '0 : per_q + 1'b1;
        start      = period_hit | scan_req;
        phase_last = (pcnt_q == PH_LAST);

        case (state_q)
            ST_IDLE: begin
                if (start || pend_q) begin
                    state_d = ST_SCAN_P0;
                    phase_d = '0;
                    pcnt_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_SCAN_P0, ST_SCAN_P1: begin
                // Starts during a scan collapse into a single follow-up scan.
                if (start) begin
                    pend_d = 1'b1;
                end
                if (phase_last) begin
                    pcnt_d  = '0;
                    phase_d = phase_q + 1'b1;
                    if (state_q == ST_SCAN_P0) begin
                        sh0_d = sample_phase(phase_q, pins_p0, sh0_q);
                    end else begin
                        sh1_d = sample_phase(phase_q, pins_p1, sh1_q);
                    end
                    if (phase_q == PHASE_LAST) begin
                        if (state_q == ST_SCAN_P0) begin
                            commit0 = 1'b1;
                            state_d = ST_SCAN_P1;
                        end else begin
                            commit1 = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        btn0_d = commit0 ? new0 : btn0_q;
        btn1_d = commit1 ? new1 : btn1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            pcnt_q  <= '0;
            per_q   <= '0;
            pend_q  <= 1'b0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            btn0_q  <= '0;
            btn1_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pcnt_q  <= pcnt_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            btn0_q  <= btn0_d;
            btn1_q  <= btn1_d;
        end
    end

    assign select_p0  = (state_q == ST_SCAN_P0) ? ~phase_q[0] : 1'b1;
    assign select_p1  = (state_q == ST_SCAN_P1) ? ~phase_q[0] : 1'b1;
    assign busy       = (state_q != ST_IDLE);
    assign buttons_p0 = btn0_q;
    assign buttons_p1 = btn1_q;

    gamepad_evt_arbiter u_arb (
        .clk          (clk),
        .rst          (rst),
        .commit_p0_i  (commit0),
        .old_p0_i     (btn0_q),
        .new_p0_i     (new0),
        .commit_p1_i  (commit1),
        .old_p1_i     (btn1_q),
        .new_p1_i     (new1),
        .evt_ready_i  (evt_ready),
        .evt_valid_o  (evt_valid),
        .evt_player_o (evt_player),
        .evt_button_o (evt_button)
    );

endmodule

// File: tb/tb_gamepad_scan_scheduler.sv
// Bench for gamepad_scan_scheduler: a pad model drives the DB9 pins per phase,
// and expected press events are queued and compared as they are accepted.
module tb_gamepad_scan_scheduler;

    localparam int PC  = 4;
    localparam int PER = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  pins_p0 = 6'h3f;
    logic [5:0]  pins_p1 = 6'h3f;
    logic        select_p0, select_p1;
    logic        scan_req = 1'b0;
    logic        busy;
    logic [11:0] buttons_p0, buttons_p1;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic        evt_player;
    logic [3:0]  evt_button;

    logic [11:0] btn0 = '0;
    logic [11:0] btn1 = '0;
    logic [4:0]  evq[$];
    int          vec = 0;
    int          miscomp = 0;
    int          sc = 0;

    gamepad_scan_scheduler #(.PHASE_CYCLES(PC), .SCAN_PERIOD(PER)) dut (
        .clk        (clk),
        .rst        (rst),
        .pins_p0    (pins_p0),
        .pins_p1    (pins_p1),
        .select_p0  (select_p0),
        .select_p1  (select_p1),
        .scan_req   (scan_req),
        .busy       (busy),
        .buttons_p0 (buttons_p0),
        .buttons_p1 (buttons_p1),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_player (evt_player),
        .evt_button (evt_button)
    );

    always #5 clk = ~clk;

    // Pad model: what a 6-button pad puts on pins 1-4/6/9 in each select phase.
    function automatic logic [5:0] pad_pins(input logic [11:0] b, input int ph);
        logic [5:0] p;
        p = 6'($urandom);
        case (ph)
            1: begin p[4] = ~b[4]; p[5] = ~b[10]; end
            2: p[3:0] = ~b[3:0];
            4: begin p[4] = ~b[5]; p[5] = ~b[6]; end
            6: begin p[0] = ~b[9]; p[1] = ~b[8]; p[2] = ~b[7]; p[3] = ~b[11]; end
            default: ;
        endcase
        return p;
    endfunction

    initial begin
        int cur;
        forever begin
            @(negedge clk);
            if (busy) begin
                cur = sc;
                sc  = (sc + 1) % 64;
            end else begin
                cur = -1;
                sc  = 0;
            end
            pins_p0 = (cur >= 0 && cur < 32) ? pad_pins(btn0, (cur / PC) % 8) : 6'($urandom);
            pins_p1 = (cur >= 32)            ? pad_pins(btn1, ((cur - 32) / PC) % 8) : 6'($urandom);
        end
    end

    // Scores an accepted event with the inputs already set for this cycle, then advances.
    task automatic tick();
        logic [4:0] e;
        if (evt_valid && evt_ready) begin
            vec++;
            if (evq.size() == 0) begin
                miscomp++;
                $display("FAIL event_unexpected: got (%0d,%0d), none expected", evt_player, evt_button);
            end else begin
                e = evq.pop_front();
                if ({evt_player, evt_button} !== e) begin
                    miscomp++;
                    $display("FAIL event_order: got (%0d,%0d) expected (%0d,%0d)",
                             evt_player, evt_button, e[4], e[3:0]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 2; i++) begin
            if (busy) quiet = 0; else quiet++;
            if (quiet < 2) tick();
        end
        if (quiet < 2) begin
            vec++; miscomp++;
            $display("FAIL wait_idle: busy still %0d after 400 cycles, expected 0", busy);
        end
    endtask

    task automatic run_scan(input logic [11:0] b0, input logic [11:0] b1);
        logic seen;
        wait_idle();
        btn0 = b0;
        btn1 = b1;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        seen = busy;
        for (int i = 0; i < 3 && !seen; i++) begin
            tick();
            seen = busy;
        end
        if (!seen) begin
            vec++; miscomp++;
            $display("FAIL scan_start: busy %0d after scan_req, expected 1", busy);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        do_reset();
        vec++;
        if ({select_p0, select_p1, busy, evt_valid, evt_player, evt_button} !== 9'b110_000_000) begin
            miscomp++;
            $display("FAIL reset_ctrl: got sel=%b%b busy=%b v=%b p=%b b=%0d expected 1 1 0 0 0 0",
                     select_p0, select_p1, busy, evt_valid, evt_player, evt_button);
        end
        vec++;
        if ({buttons_p0, buttons_p1} !== 24'h0) begin
            miscomp++;
            $display("FAIL reset_buttons: got %h/%h expected 000/000", buttons_p0, buttons_p1);
        end
    endtask

    task automatic test_period();
        int s, ph;
        logic eb, e0, e1;
        for (int k = 0; k < 275; k++) begin
            s  = k - PER;
            ph = (s >= 0) ? (s / PC) % 8 : 0;
            eb = (s >= 0 && s < 64);
            e0 = (s >= 0 && s < 32) ? (ph % 2 == 0) : 1'b1;
            e1 = (s >= 32 && s < 64) ? (ph % 2 == 0) : 1'b1;
            vec++;
            if ({busy, select_p0, select_p1} !== {eb, e0, e1}) begin
                miscomp++;
                $display("FAIL period_cycle%0d: got busy/sel0/sel1=%b%b%b expected %b%b%b",
                         k, busy, select_p0, select_p1, eb, e0, e1);
            end
            tick();
        end
    endtask

    task automatic test_press_events();
        evt_ready = 1'b1;
        evq.push_back({1'b0, 4'd0});
        evq.push_back({1'b0, 4'd4});
        run_scan(12'h011, 12'h000);
`ifndef GAMEPAD_DEBOUNCE_EN
        vec++;
        if (buttons_p0 !== 12'h011) begin
            miscomp++;
            $display("FAIL press_first_commit: got %h expected 011", buttons_p0);
        end
`endif
        run_scan(12'h011, 12'h000);
        vec++;
        if (buttons_p0 !== 12'h011 || buttons_p1 !== 12'h000) begin
            miscomp++;
            $display("FAIL press_buttons: got %h/%h expected 011/000", buttons_p0, buttons_p1);
        end
        vec++;
        if (evq.size() != 0) begin
            miscomp++;
            $display("FAIL press_queue: %0d events outstanding, expected 0", evq.size());
            evq.delete();
        end
    endtask

    task automatic test_two_players();
        evq.push_back({1'b0, 4'd5});
        evq.push_back({1'b1, 4'd10});
        run_scan(12'h020, 12'h400);
        run_scan(12'h020, 12'h400);
        vec++;
        if (buttons_p0 !== 12'h020 || buttons_p1 !== 12'h400) begin
            miscomp++;
            $display("FAIL two_buttons: got %h/%h expected 020/400", buttons_p0, buttons_p1);
        end
        vec++;
        if (evq.size() != 0) begin
            miscomp++;
            $display("FAIL two_queue: %0d events outstanding, expected 0", evq.size());
            evq.delete();
        end
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        run_scan(12'h1A0, 12'h600);
        run_scan(12'h1A0, 12'h600);
        vec++;
        if ({evt_valid, evt_player, evt_button} !== {1'b1, 1'b0, 4'd7}) begin
            miscomp++;
            $display("FAIL rr_hold: got v=%b (%0d,%0d) expected v=1 (0,7)", evt_valid, evt_player, evt_button);
        end
        evq.push_back({1'b0, 4'd7});
        evq.push_back({1'b1, 4'd9});
        evq.push_back({1'b0, 4'd8});
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec++;
            if (evt_valid !== 1'b1) begin
                miscomp++;
                $display("FAIL rr_burst%0d: evt_valid %b expected 1", i, evt_valid);
            end
            tick();
        end
        vec++;
        if (evt_valid !== 1'b0) begin
            miscomp++;
            $display("FAIL rr_drained: evt_valid %b expected 0", evt_valid);
        end
        vec++;
        if (evq.size() != 0) begin
            miscomp++;
            $display("FAIL rr_queue: %0d events outstanding, expected 0", evq.size());
            evq.delete();
        end
    endtask

    task automatic test_stall_release();
        evt_ready = 1'b0;
        run_scan(12'h1E0, 12'h600);
        run_scan(12'h1E0, 12'h600);
        vec++;
        if ({evt_valid, evt_player, evt_button} !== {1'b1, 1'b0, 4'd6}) begin
            miscomp++;
            $display("FAIL stall_press: got v=%b (%0d,%0d) expected v=1 (0,6)", evt_valid, evt_player, evt_button);
        end
        run_scan(12'h1A0, 12'h600);
        run_scan(12'h1A0, 12'h600);
        vec++;
        if ({evt_valid, evt_player, evt_button} !== {1'b1, 1'b0, 4'd6}) begin
            miscomp++;
            $display("FAIL stall_release: got v=%b (%0d,%0d) expected v=1 (0,6)", evt_valid, evt_player, evt_button);
        end
        vec++;
        if (buttons_p0 !== 12'h1A0) begin
            miscomp++;
            $display("FAIL stall_buttons: got %h expected 1a0", buttons_p0);
        end
        evq.push_back({1'b0, 4'd6});
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        vec++;
        if (evt_valid !== 1'b0 || evq.size() != 0) begin
            miscomp++;
            $display("FAIL stall_deliver: evt_valid %b queue %0d expected 0 0", evt_valid, evq.size());
            evq.delete();
        end
    endtask

    task automatic test_pending_req();
        logic eb;
        btn0 = '0;
        btn1 = '0;
        do_reset();
        for (int k = 0; k < 196; k++) begin
            scan_req = (k == 0 || k == 20 || k == 30);
            eb = (k >= 1 && k <= 64) || (k >= 66 && k <= 129);
            vec++;
            if (busy !== eb) begin
                miscomp++;
                $display("FAIL pending_cycle%0d: busy %b expected %b", k, busy, eb);
            end
            tick();
        end
        scan_req = 1'b0;
    endtask

    task automatic test_reset_midscan();
        btn0 = '0;
        btn1 = 12'h00F;
        evt_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 46; k++) begin
            scan_req = (k == 0);
            tick();
        end
        vec++;
        if ({busy, select_p0, select_p1} !== 3'b110) begin
            miscomp++;
            $display("FAIL midscan_phase3: busy/sel0/sel1=%b%b%b expected 110", busy, select_p0, select_p1);
        end
        rst = 1'b1;
        tick();
        vec++;
        if ({busy, select_p0, select_p1, evt_valid} !== 4'b0110 || buttons_p1 !== 12'h000) begin
            miscomp++;
            $display("FAIL midscan_abort: busy/sel0/sel1/v=%b%b%b%b p1=%h expected 0110 000",
                     busy, select_p0, select_p1, evt_valid, buttons_p1);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) evq.push_back({1'b1, 4'(i)});
        run_scan(12'h000, 12'h00F);
        run_scan(12'h000, 12'h00F);
        vec++;
        if (buttons_p1 !== 12'h00F || evq.size() != 0) begin
            miscomp++;
            $display("FAIL midscan_rescan: p1=%h queue %0d expected 00f 0", buttons_p1, evq.size());
            evq.delete();
        end
    endtask

`ifdef GAMEPAD_DEBOUNCE_EN
    task automatic test_debounce();
        run_scan(12'h200, 12'h00F);
        run_scan(12'h000, 12'h00F);
        run_scan(12'h000, 12'h00F);
        vec++;
        if (buttons_p0 !== 12'h000 || evq.size() != 0) begin
            miscomp++;
            $display("FAIL debounce_glitch: p0=%h queue %0d expected 000 0", buttons_p0, evq.size());
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_period();
        test_press_events();
        test_two_players();
        test_back_to_back();
        test_stall_release();
        test_pending_req();
        test_reset_midscan();
`ifdef GAMEPAD_DEBOUNCE_EN
        test_debounce();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule

// File: doc/gamepad_scan_scheduler.md
# gamepad_scan_scheduler

Two-player DB9 gamepad scan scheduler. A single phase sequencer is shared between both controller ports: P0 is scanned, then P1, once per scan period or on request. Each player's 12-bit button state is committed atomically at the end of its scan. Newly pressed buttons are queued as single-button events and delivered to game logic through a round-robin valid/ready port.

## Interface
- `PHASE_CYCLES`, default 1000: clock cycles per select phase (20 µs at 50 MHz).
- `SCAN_PERIOD`, default 833333: cycles between automatic scan starts (~60 Hz); must exceed 16*`PHASE_CYCLES`.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `pins_p0` in 6: P0 DB9 inputs, active-low; bit0 pin1 up/Z, bit1 pin2 down/Y, bit2 pin3 left/X, bit3 pin4 right/mode, bit4 pin6 B/A, bit5 pin9 C/start.
- `pins_p1` in 6: P1 inputs, same order.
- `select_p0` out 1: P0 DB9 pin 7.
- `select_p1` out 1: P1 DB9 pin 7.
- `scan_req` in 1: one-cycle pulse requesting an immediate scan.
- `busy` out 1: scan in progress.
- `buttons_p0` out 12: P0 state, active-high. Bit order: 0 up, 1 down, 2 left, 3 right, 4 A, 5 B, 6 C, 7 X, 8 Y, 9 Z, 10 start, 11 mode.
- `buttons_p1` out 12: P1 state, same order.
- `evt_valid` out 1: press event available.
- `evt_ready` in 1: consumer accepts the event.
- `evt_player` out 1: 0 = P0, 1 = P1.
- `evt_button` out 4: button index 0..11.

## Operation
- **States:** IDLE, SCAN_P0, SCAN_P1.
  - SCAN_Px runs phases 0..7, each exactly `PHASE_CYCLES` cycles.
  - The active player's select is high in even phases and low in odd phases.
  - The inactive player's select is held high.
- **Start condition:** IDLE goes to SCAN_P0 when the period counter reaches `SCAN_PERIOD`-1, or when `scan_req` is high.
  - The period counter is free-running and wraps to 0 at that point.
- **Start during a scan:** a start condition arriving during a scan sets one pending flag. Further starts are not counted. The pending flag makes IDLE leave immediately after the current scan.
- **Sampling:** on the last cycle of a phase, inverted pins are sampled into a per-player shadow register.
  - Phase 1: A = pin6, start = pin9.
  - Phase 2: up, down, left, right = pins 1–4.
  - Phase 4: B = pin6, C = pin9.
  - Phase 6: Z = pin1, Y = pin2, X = pin3, mode = pin4.
- **Commit:** on the last cycle of phase 7, the shadow register becomes the player's committed value.
  - `buttons_px` updates on the next clock edge, all 12 bits together.
  - SCAN_P0 is followed by SCAN_P1; SCAN_P1 is followed by IDLE.
- **Press detection:** at commit, `pend_px |= new & ~old`, giving a 12-bit pending mask per player.
- **Event selection:**
  - `evt_valid` = any pending bit set in either mask.
  - The player is chosen round-robin: prefer the player not served last, otherwise whichever has pending bits.
  - `evt_button` is the lowest set bit of the chosen player's mask.
- **Handshake:**
  - On `evt_valid && evt_ready`, the presented bit is cleared and the last-served pointer is updated.
  - `evt_player` and `evt_button` hold stable while `evt_valid` is high and `evt_ready` is low.
- **Simultaneous commit and handshake:** the acknowledged bit is cleared and newly detected bits are set in the same cycle; set wins on the same bit.
- **Release:** releases generate no event. A bit still pending after its button is released stays pending.

## Timing
- **Reset values:** `select_p0`/`select_p1` = 1, `busy` = 0, `buttons_p0`/`buttons_p1` = 0, `evt_valid` = 0, `evt_player` = 0, `evt_button` = 0.
  - Internal: state IDLE, pending masks 0, scan-pending flag 0, period counter 0, last-served = P1.
- `busy` is high from the first SCAN_P0 cycle through the last SCAN_P1 cycle.
- A full scan is 16*`PHASE_CYCLES` cycles; there are no gap cycles between players.
- `scan_req` in IDLE: SCAN_P0 begins on the next cycle.
- Commit → `buttons_px` visible 1 cycle later; `evt_valid` also rises 1 cycle after commit.
- Event output is registered. After acceptance, the next event is presented on the following cycle, so back-to-back events run at 1 per cycle.
- Reset mid-scan aborts with no commit; shadow registers are cleared.

## Configuration
- **`GAMEPAD_DEBOUNCE_EN` defined:** a committed bit changes only when the current scan's sample equals the previous scan's raw sample for that bit and player; otherwise the old value is kept. The previous raw samples are per player and reset to 0.
- **Not defined:** the shadow register is committed directly; there is no raw-history storage.

## Structure
- **Package `gamepad_pkg`:**
  - button index constants (`BTN_UP` .. `BTN_MODE`);
  - the pin index constants;
  - the scheduler state encoding;
  - `NUM_BUTTONS` = 12.
- **Sub-module `gamepad_evt_arbiter`:** pending masks, round-robin player choice, priority encoder and valid/ready handshake. Its inputs are the commit strobes plus old/new values.
- Sequencer, period counter, sampling and commit stay in the top module.

## Test plan
Bench parameters: `PHASE_CYCLES`=4, `SCAN_PERIOD`=200.
1. Reset, then idle 199 cycles → `busy` rises at cycle 200; selects toggle every 4 cycles; P0 low in phases 1/3/5/7 while P1 stays high; `busy` lasts 64 cycles.
2. P0 holds A (pin6 low only during its phase 1) and up → after the P0 commit, `buttons_p0` = 12'h011. Expect events (0,0), then (0,4), with `evt_ready` held high.
3. P0 presses B and P1 presses start in the same scan; `evt_ready` = 1 → event order is (0,5), then (1,10) by round-robin; `evt_valid` drops after 2 cycles.
4. `scan_req` pulsed mid-scan twice → exactly one extra scan follows immediately after `busy` falls.
5. Hold `evt_ready` = 0 while a press of C (bit 6) is pending, then release the button → (0,6) stays stable and is delivered once `evt_ready` = 1; no release event.
6. `rst` at phase 3 of SCAN_P1 → `buttons_p1` stays at its old value, selects = 1, `evt_valid` = 0. With `GAMEPAD_DEBOUNCE_EN`, a press present for only one scan never reaches `buttons_p0`.
